// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared types, defaults and round-robin pick helper for the PCI arbiter
package pci_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY
    } arb_state_t;

    localparam int N_MASTERS_DEF = 4;
    localparam int TIMEOUT_DEF   = 16;

    // The helper works on a fixed 8-wide request vector so it can live in the
    // package without knowing the instance's master count.
    localparam int PICK_MAX   = 8;
    localparam int PICK_IDX_W = 3;

    typedef struct packed {
        logic                  hit;
        logic [PICK_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester found searching upward from ptr+1, wrapping at n.
    function automatic rr_pick_t rr_pick(
        input logic [PICK_MAX-1:0]   req,
        input logic [PICK_IDX_W-1:0] ptr,
        input int                    n
    );
        rr_pick_t              res;
        int                    cand;
        logic [PICK_IDX_W-1:0] cand_idx;
        res.hit = 1'b0;
        res.idx = '0;
        // Walk from the farthest candidate to the nearest so the nearest hit
        // is the one left standing.
        for (int k = PICK_MAX; k >= 1; k--) begin
            if (k <= n) begin
                cand = int'(ptr) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                cand_idx = PICK_IDX_W'(cand);
                if (req[cand_idx]) begin
                    res.hit = 1'b1;
                    res.idx = cand_idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// rtl/pci_rr_picker.sv - combinational rotate-priority encoder for round-robin grant selection
module pci_rr_picker
    import pci_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int ID_W      = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic                 hit,
    output logic [ID_W-1:0]      idx
);

    logic [PICK_MAX-1:0]   req_ext;
    logic [PICK_IDX_W-1:0] ptr_ext;
    rr_pick_t              pick;

    // Widen to the helper's fixed width, pick, and narrow back to ID_W.
    always_comb begin
        req_ext = PICK_MAX'(req);
        ptr_ext = PICK_IDX_W'(ptr);
        pick    = rr_pick(req_ext, ptr_ext, N_MASTERS);
        hit     = pick.hit;
        idx     = ID_W'(pick.idx);
    end

endmodule

// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - central round-robin PCI bus arbiter with unused-grant timeout
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int ID_W      = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req_n,
    input  logic                 frame_n,
    input  logic                 irdy_n,
    output logic [N_MASTERS-1:0] gnt_n,
    output logic                 owner_valid,
    output logic [ID_W-1:0]      owner_id,
    output logic                 bus_idle
);

    localparam int               TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  PTR_RESET = ID_W'(N_MASTERS - 1);

    arb_state_t           state;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      rr_ptr;
    logic [TMR_W-1:0]     timer;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] own_mask;
    logic [N_MASTERS-1:0] pick_onehot;
    logic                 pick_hit;
    logic [ID_W-1:0]      pick_idx;
    logic                 owner_req;
    logic                 others_req;

    assign bus_idle = frame_n & irdy_n;
    assign req      = ~req_n;

    pci_rr_picker #(
        .N_MASTERS (N_MASTERS),
        .ID_W      (ID_W)
    ) u_picker (
        .req (req),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // Split the live requests into the current grantee's and everyone else's.
    always_comb begin
        own_mask    = N_MASTERS'(1) << gnt_idx;
        pick_onehot = N_MASTERS'(1) << pick_idx;
        owner_req   = |(req & own_mask);
        others_req  = |(req & ~own_mask);
    end

    // Arbitration FSM; every output it drives is a flop so grants never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_n       <= '1;
            gnt_idx     <= '0;
            rr_ptr      <= PTR_RESET;
            timer       <= '0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Passing through IDLE with all grants high is what gives
                    // the dead cycle between consecutive owners.
                    gnt_n <= '1;
                    if (pick_hit) begin
                        gnt_idx <= pick_idx;
                        gnt_n   <= ~pick_onehot;
                        timer   <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!frame_n) begin
                        // FRAME beats a simultaneous request release.
                        state       <= BUSY;
                        owner_valid <= 1'b1;
                        owner_id    <= gnt_idx;
                        rr_ptr      <= gnt_idx;
                    end else if (!owner_req) begin
                        gnt_n <= '1;
                        state <= IDLE;
                    end else if (bus_idle && (timer == TMR_LAST) && others_req) begin
                        // Unused grant: move the pointer past this master so
                        // the next search starts with its neighbour.
                        gnt_n  <= '1;
                        rr_ptr <= gnt_idx;
                        state  <= IDLE;
                    end else if (bus_idle && (timer != TMR_LAST)) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                BUSY: begin
                    // Owner already holds FRAME, so the grant can go away.
                    gnt_n <= '1;
                    if (bus_idle) begin
                        owner_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    gnt_n       <= '1;
                    owner_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
